gated_edge_counter: RTL and testbench
=====================================

# gated_edge_counter

Measures the rates of the two external pulse trains `clkA` and `clkB` in the `clk` domain. Both inputs are asynchronous. The block synchronises each one, counts its rising edges over a fixed gate window of `GATE` core cycles, and presents the two counts as `A_val`/`B_val` with a one-cycle `valid` strobe at the end of every window. It is the stage directly upstream of the count-compare/PWM logic that consumes `A_val` and `B_val`.

## Interface
- `CW`, default 7: width of each edge count and of `A_val`/`B_val`.
- `GATE`, default 200: gate window length in `clk` cycles (1 µs at 200 MHz); legal range 2..65535.
- `clk` input 1: core clock, 200 MHz nominal; all state on its rising edge.
- `reset` input 1: synchronous, active-low reset (asserted when 0).
- `en` input 1: count enable; 0 freezes the window.
- `clkA` input 1: asynchronous pulse train A.
- `clkB` input 1: asynchronous pulse train B.
- `A_val` output CW: rising edges of A in the last completed window.
- `B_val` output CW: rising edges of B in the last completed window.
- `valid` output 1: one-cycle pulse when `A_val`/`B_val` update.
- `ovfA` output 1: A count saturated in the last completed window.
- `ovfB` output 1: B count saturated in the last completed window.

## Operation
- Synchroniser per input: two flops `s1`→`s2`, plus a history flop `s3`. A rising edge is detected in the cycle where `s2 & ~s3`. The synchroniser and history flops run regardless of `en`.
- Gate counter `g`, width ceil(log2(GATE)):
  - counts 0..GATE-1 while `en`=1;
  - wraps from GATE-1 to 0;
  - holds while `en`=0.
- Edge counters `ca`, `cb` (CW bits):
  - increment by 1 on a detected edge while `en`=1;
  - saturate at 2^CW−1; a sticky per-window flag sets when an edge arrives while the counter is already at max;
  - edges detected while `en`=0 are discarded, not deferred.
- Window close: the cycle with `g`==GATE-1 and `en`=1.
  - Latch `A_val`=`ca`+edgeA (saturating) and `B_val`=`cb`+edgeB (saturating). An edge detected in the closing cycle belongs to the closing window.
  - Latch `ovfA`/`ovfB` from the sticky flags, including any saturation caused in the closing cycle.
  - Clear `ca`, `cb` and both flags to 0. Pulse `valid`.
- Outputs `A_val`, `B_val`, `ovfA`, `ovfB` hold between window closes.
- Reset (`reset`=0 at a `clk` edge): `g`, `ca`, `cb`, flags, `s1`..`s3`, `A_val`, `B_val`, `ovfA`, `ovfB` and `valid` all go to 0. A partial window in progress is abandoned, with no `valid`. After release, the first window starts with `g`=0.
- Input constraint: `clkA`/`clkB` high and low phases ≥ 2 `clk` periods. Narrower pulses may be missed; this is not detected.

## Timing
- Input rising edge → `s2` high: 2–3 cycles, depending on phase. Edge detect fires in the cycle `s2` first reads 1.
- Counting starts on the first `clk` edge with `reset`=1 and `en`=1 (`g`=0 → 1).
- With `en` held high, `valid` is registered and high exactly one cycle after the closing cycle; `A_val`/`B_val` change on that same edge. Period: exactly GATE cycles. The first `valid` comes GATE cycles after reset release.
- `en` low for N cycles stretches the current window by N cycles. `valid` never asserts while `en`=0 in the closing position.
- `reset` asserted in the same cycle as a window close: reset wins, with no update and no `valid`.

## Test plan
- Default parameters, `clk` 5 ns, `clkA` 250 ns, `clkB` 200 ns, `en`=1 → after the first window, every `valid` (period 200 cycles) shows `A_val`=4, `B_val`=5, `ovfA`=`ovfB`=0.
- `GATE`=1000, `clkA` period 20 ns → `A_val`=127, `ovfA`=1, `B_val`=25, `ovfB`=0 (`clkB`=200 ns); restore `clkA`=250 ns → next window `A_val`=20, `ovfA`=0.
- Deassert `en` for 37 cycles mid-window → next `valid` delayed by exactly 37 cycles; counts exclude edges arriving during those 37 cycles.
- Phase `clkB` so its detected edge lands on `g`=GATE-1 → that edge is counted in the closing window (B_val includes it); the next window's count starts at 0.
- Assert `reset`=0 for 1 cycle at `g`=150 → all outputs 0 on the next edge, no `valid`; the next `valid` comes 200 cycles after release.
- Outputs are 0 throughout reset; `valid` is never high for two consecutive cycles.

Source files
------------

// File: rtl/gated_edge_counter.sv
`timescale 1ns/1ps
// Counts rising edges of two asynchronous pulse trains over a fixed gate window of core cycles.
// At each window close, the block latches both counts and their saturation flags and pulses valid.
module gated_edge_counter #(
    parameter int unsigned CW   = 7,
    parameter int unsigned GATE = 200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clkA,
    input  logic          clkB,
    output logic [CW-1:0] A_val,
    output logic [CW-1:0] B_val,
    output logic          valid,
    output logic          ovfA,
    output logic          ovfB
);

    localparam int unsigned GW     = (GATE > 1) ? $clog2(GATE) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GATE - 1);
    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};

    logic          a_s1, a_s2, a_s3;
    logic          b_s1, b_s2, b_s3;
    logic [GW-1:0] g;
    logic [CW-1:0] ca, cb;
    logic          sat_a, sat_b;

    logic          edge_a_c, edge_b_c;
    logic          full_a_c, full_b_c;
    logic          close_c;
    logic [CW-1:0] ca_next_c, cb_next_c;

    // Edge detection, saturating increment and window-close decode
    always_comb begin
        edge_a_c  = a_s2 & ~a_s3;
        edge_b_c  = b_s2 & ~b_s3;
        full_a_c  = edge_a_c & (ca == C_MAX);
        full_b_c  = edge_b_c & (cb == C_MAX);
        ca_next_c = ca;
        cb_next_c = cb;
        if (edge_a_c && !full_a_c) begin
            ca_next_c = ca + CW'(1);
        end
        if (edge_b_c && !full_b_c) begin
            cb_next_c = cb + CW'(1);
        end
        close_c = en & (g == G_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_s1  <= 1'b0;
            a_s2  <= 1'b0;
            a_s3  <= 1'b0;
            b_s1  <= 1'b0;
            b_s2  <= 1'b0;
            b_s3  <= 1'b0;
            g     <= '0;
            ca    <= '0;
            cb    <= '0;
            sat_a <= 1'b0;
            sat_b <= 1'b0;
            A_val <= '0;
            B_val <= '0;
            ovfA  <= 1'b0;
            ovfB  <= 1'b0;
            valid <= 1'b0;
        end else begin
            a_s1  <= clkA;
            a_s2  <= a_s1;
            a_s3  <= a_s2;
            b_s1  <= clkB;
            b_s2  <= b_s1;
            b_s3  <= b_s2;
            valid <= 1'b0;
            if (en) begin
                if (close_c) begin
                    // An edge seen in the closing cycle still belongs to the closing window
                    g     <= '0;
                    A_val <= ca_next_c;
                    B_val <= cb_next_c;
                    ovfA  <= sat_a | full_a_c;
                    ovfB  <= sat_b | full_b_c;
                    ca    <= '0;
                    cb    <= '0;
                    sat_a <= 1'b0;
                    sat_b <= 1'b0;
                    valid <= 1'b1;
                end else begin
                    g     <= g + GW'(1);
                    ca    <= ca_next_c;
                    cb    <= cb_next_c;
                    sat_a <= sat_a | full_a_c;
                    sat_b <= sat_b | full_b_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_gated_edge_counter.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for gated_edge_counter: a window-level reference model predicts
// every valid, and a monitor checks timing, values, hold behaviour and reset.
module tb_gated_edge_counter;

    localparam int unsigned CW   = 5;
    localparam int unsigned GATE = 200;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          en    = 1'b0;
    logic          clkA  = 1'b0;
    logic          clkB  = 1'b0;
    logic [CW-1:0] A_val, B_val;
    logic          valid, ovfA, ovfB;

    gated_edge_counter #(.CW(CW), .GATE(GATE)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clkA  (clkA),
        .clkB  (clkB),
        .A_val (A_val),
        .B_val (B_val),
        .valid (valid),
        .ovfA  (ovfA),
        .ovfB  (ovfB)
    );

    always #2.5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        bit oa;
        bit ob;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rst_applied = 1'b1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Reference model: per-edge input samples; an edge counts two samples after the low->high change.
    bit hist_a[$];
    bit hist_b[$];
    int tot_a = 0, tot_b = 0, pos = 0;

    always @(posedge clk) begin
        bit ea, eb;
        cyc++;
        rst_applied = !reset;
        if (!reset) begin
            hist_a = {1'b0, 1'b0, 1'b0, 1'b0};
            hist_b = {1'b0, 1'b0, 1'b0, 1'b0};
            tot_a  = 0;
            tot_b  = 0;
            pos    = 0;
        end else begin
            ea = hist_a[$-1] && !hist_a[$-2];
            eb = hist_b[$-1] && !hist_b[$-2];
            hist_a.push_back(clkA);
            void'(hist_a.pop_front());
            hist_b.push_back(clkB);
            void'(hist_b.pop_front());
            if (en) begin
                tot_a += int'(ea);
                tot_b += int'(eb);
                if (pos == GATE - 1) begin
                    sb.push_back('{a: (tot_a > CMAX) ? CMAX : tot_a,
                                   b: (tot_b > CMAX) ? CMAX : tot_b,
                                   oa: (tot_a > CMAX), ob: (tot_b > CMAX), due: cyc});
                    tot_a = 0;
                    tot_b = 0;
                    pos   = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on valid, otherwise checks outputs hold their last values
    bit prev_valid = 1'b0;
    int h_a = 0, h_b = 0, h_oa = 0, h_ob = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_applied) begin
            h_a  = 0;
            h_b  = 0;
            h_oa = 0;
            h_ob = 0;
        end
        if (valid) begin
            check("valid_back_to_back", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("valid_cycle", cyc, e.due);
                check("A_val", int'(A_val), e.a);
                check("B_val", int'(B_val), e.b);
                check("ovfA", int'(ovfA), int'(e.oa));
                check("ovfB", int'(ovfB), int'(e.ob));
                h_a  = e.a;
                h_b  = e.b;
                h_oa = int'(e.oa);
                h_ob = int'(e.ob);
            end
        end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("missing_valid", 0, 1);
                void'(sb.pop_front());
            end
            check("A_val_hold", int'(A_val), h_a);
            check("B_val_hold", int'(B_val), h_b);
            check("ovfA_hold", int'(ovfA), h_oa);
            check("ovfB_hold", int'(ovfB), h_ob);
        end
        prev_valid = valid;
    end

    // Pulse-train generators: each phase lasts a random number of cycles in [lo, hi]
    int a_lo = 25, a_hi = 25, b_lo = 20, b_hi = 20;
    int a_rem = 1, b_rem = 1;

    task automatic tick();
        @(posedge clk);
        #1;
        a_rem--;
        if (a_rem <= 0) begin
            clkA  = ~clkA;
            a_rem = int'($urandom_range(a_hi, a_lo));
        end
        b_rem--;
        if (b_rem <= 0) begin
            clkB  = ~clkB;
            b_rem = int'($urandom_range(b_hi, b_lo));
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        run(5);
        reset = 1'b1;
        en    = 1'b1;
        run(5 * GATE);

        // Saturate A, then recover
        a_lo = 2; a_hi = 2;
        run(3 * GATE);
        a_lo = 25; a_hi = 25;
        run(3 * GATE);

        // Enable dropout mid-window
        run(60);
        en = 1'b0;
        run(37);
        en = 1'b1;
        run(3 * GATE);

        // One-cycle reset at g == 150
        for (int i = 0; i < 2 * GATE && pos != 150; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run(2 * GATE + 5);

        // Randomised rates, enable gaps and occasional resets
        for (int k = 0; k < 40; k++) begin
            a_lo = int'($urandom_range(6, 2));
            a_hi = a_lo + int'($urandom_range(30, 0));
            b_lo = int'($urandom_range(6, 2));
            b_hi = b_lo + int'($urandom_range(30, 0));
            run(int'($urandom_range(300, 50)));
            if ($urandom_range(3, 0) == 0) begin
                en = 1'b0;
                run(int'($urandom_range(50, 1)));
                en = 1'b1;
            end
            if ($urandom_range(9, 0) == 0) begin
                reset = 1'b0;
                run(int'($urandom_range(3, 1)));
                reset = 1'b1;
            end
        end

        en    = 1'b1;
        reset = 1'b1;
        run(GATE + 5);
        check("pending_at_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
